// File: rtl/reaction_session_ctrl.sv
// reaction_session_ctrl: sequences ROUNDS reaction trials on the core, accumulates best/total, selects displayed value
//   clk, rst_n (async active-low) | start_btn, abort_btn: raw async buttons
//   core_go/core_done/core_ms/core_early: trial handshake with the reaction-time core
//   value/disp_sel: display number and source | round, led_err, session_done: status
module reaction_session_ctrl #(
  parameter int ROUNDS   = 4,
  parameter int HOLD_CYC = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        abort_btn,
  output logic        core_go,
  input  logic        core_done,
  input  logic [13:0] core_ms,
  input  logic        core_early,
  output logic [13:0] value,
  output logic [1:0]  disp_sel,
  output logic [2:0]  round,
  output logic        led_err,
  output logic        session_done
);
  localparam int          SH        = $clog2(ROUNDS);
  localparam logic [13:0] MS_MAX    = 14'd9999;
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYC - 1);
  localparam logic [2:0]  LAST_RND  = 3'(ROUNDS - 1);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, SHOW, SUM_BEST, SUM_AVG} state_t;
  state_t state, state_n;
  logic [2:0]  start_sync, abort_sync;
  logic        start_p, abort_p;
  logic [13:0] ms_s, last, best;
  logic [16:0] sum;
  logic [23:0] hold_cnt;
  logic        hold_done, accept, new_session, holding;
  assign ms_s        = core_ms > MS_MAX ? MS_MAX : core_ms;
  assign hold_done   = hold_cnt == HOLD_LAST;
  assign holding     = state == SHOW || state == SUM_BEST;
  // abort outranks a coincident core_done, so the result is dropped
  assign accept      = state == WAIT && core_done && !abort_p;
  assign new_session = !abort_p && start_p && (state == IDLE || state == SUM_AVG);
  always_comb begin
    state_n = state;
    if (abort_p) state_n = IDLE;
    else
      case (state)
        IDLE:     state_n = start_p ? ARM : IDLE;
        ARM:      state_n = WAIT;
        WAIT:     state_n = core_done ? SHOW : WAIT;
        SHOW:     state_n = !hold_done ? SHOW : (led_err || round != LAST_RND) ? ARM : SUM_BEST;
        SUM_BEST: state_n = hold_done ? SUM_AVG : SUM_BEST;
        SUM_AVG:  state_n = start_p ? ARM : SUM_AVG;
        default:  state_n = IDLE;
      endcase
  end
  always_comb begin
    value    = 14'd0;
    disp_sel = 2'd0;
    case (state)
      WAIT:     value = ms_s;
      SHOW:     begin value = led_err ? 14'd0 : last; disp_sel = 2'd1; end
      SUM_BEST: begin value = best; disp_sel = 2'd2; end
      SUM_AVG:  begin value = 14'(sum >> SH); disp_sel = 2'd3; end
      default:  value = 14'd0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_sync   <= '0;
      abort_sync   <= '0;
      start_p      <= 1'b0;
      abort_p      <= 1'b0;
      core_go      <= 1'b0;
      session_done <= 1'b0;
      led_err      <= 1'b0;
      round        <= '0;
      last         <= '0;
      best         <= MS_MAX;
      sum          <= '0;
      hold_cnt     <= '0;
    end else begin
      start_sync   <= {start_sync[1:0], start_btn};
      abort_sync   <= {abort_sync[1:0], abort_btn};
      // registered edge pulses put action 3 edges after the first sample
      start_p      <= start_sync[1] & ~start_sync[2];
      abort_p      <= abort_sync[1] & ~abort_sync[2];
      state        <= state_n;
      core_go      <= state_n == ARM;
      session_done <= state_n == SUM_BEST || state_n == SUM_AVG;
      if (abort_p) begin
        best     <= MS_MAX;
        sum      <= '0;
        round    <= '0;
        led_err  <= 1'b0;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= holding && !hold_done ? hold_cnt + 24'd1 : 24'd0;
        if (new_session) begin
          best  <= MS_MAX;
          sum   <= '0;
          round <= '0;
        end
        if (accept) begin
          last <= ms_s;
          if (core_early) led_err <= 1'b1;
          else begin
            sum  <= sum + {3'b0, ms_s};
            best <= ms_s < best ? ms_s : best;
          end
        end
        if (state == SHOW && hold_done) begin
          led_err <= 1'b0;
          if (!led_err && round != LAST_RND) round <= round + 3'd1;
        end
      end
    end
  end
endmodule

// File: doc/reaction_session_ctrl.md
# reaction_session_ctrl

Session sequencer for the reaction-time tester. It runs a fixed number of trials on the reaction-time core through a go/done handshake. It retries false starts and accumulates best and total times. It then decides which value the 7-segment display path shows: live timer, last result, best, or average. It sits between the board buttons and the reaction-time core, and its `value` output feeds the display multiplexer in place of the core's own value.

## Interface
Parameters:
- `ROUNDS`, 4, trials per session; legal values 1, 2, 4, 8 (average computed by shift)
- `HOLD_CYC`, 10_000_000, clock cycles each result or summary screen is held

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start_btn`  in  1  raw start button, level, asynchronous to `clk`
- `abort_btn`  in  1  raw abort button, level, asynchronous to `clk`
- `core_go`  out  1  one-cycle pulse: core begins one trial
- `core_done`  in  1  one-cycle pulse: trial finished, `core_ms`/`core_early` valid
- `core_ms`  in  14  trial time in ms; in WAIT also the live running count
- `core_early`  in  1  false start, qualified by `core_done`
- `value`  out  14  number to display, 0..9999
- `disp_sel`  out  2  0 live, 1 last, 2 best, 3 average
- `round`  out  3  index of current trial, 0..ROUNDS-1
- `led_err`  out  1  high while a false-start result is shown
- `session_done`  out  1  high in summary states

## Operation
- Buttons: 2-FF synchronizer each, then rising-edge detect against a third register. Only edges act.
- `core_ms` is saturated to 9999 before any use. `ms_s` = min(`core_ms`, 9999).
- Accumulators:
  - `best` is 14 bits and resets to 9999.
  - `sum` is 17 bits and resets to 0; max 8×9999 = 79992, so it never overflows.
  - `avg` = `sum` >> log2(ROUNDS), truncated.
- States:
  - IDLE: `value`=0, `disp_sel`=0. Start edge → clear `best`/`sum`/`round` → ARM.
  - ARM: `core_go`=1 for this cycle only → WAIT.
  - WAIT: `value`=`ms_s` (live), `disp_sel`=0. On `core_done`, latch `last`=`ms_s`.
    - If `core_early`=1: set `led_err` → SHOW; the round is not counted.
    - Otherwise: `sum`+=`ms_s`, `best`=min(`best`,`ms_s`) → SHOW.
  - SHOW: `value`=`last` (0 if early), `disp_sel`=1, hold `HOLD_CYC` cycles, then clear `led_err`.
    - If early: → ARM, same `round`.
    - Else if `round`==ROUNDS-1: → SUM_BEST.
    - Else: `round`+1 → ARM.
  - SUM_BEST: `value`=`best`, `disp_sel`=2, `session_done`=1, hold `HOLD_CYC` → SUM_AVG.
  - SUM_AVG: `value`=`avg`, `disp_sel`=3, `session_done`=1. Holds indefinitely.
    - Start edge → new session (clear, → ARM).
- Start edges in ARM/WAIT/SHOW/SUM_BEST are ignored.
- Abort edge in any state → IDLE next cycle. It clears `best`, `sum`, `round`, `led_err` and the hold counter. No `core_go` is issued.
- `core_done` outside WAIT is ignored.
- Simultaneous abort edge and `core_done` in WAIT: abort wins and the result is discarded.

## Timing
- All outputs are registered except `value`/`disp_sel`, which are decoded from registered state and registers. They may be combinational from `core_ms` in WAIT.
- Reset values:
  - State IDLE; `core_go`=0, `value`=0, `disp_sel`=0, `round`=0, `led_err`=0, `session_done`=0.
  - `best`=9999, `sum`=0, hold counter 0.
- Start latency: `start_btn` first sampled high at edge k → `core_go` high in the cycle after edge k+3, for exactly 1 cycle.
- Abort latency: 3 edges to the edge-detect, plus 1 edge to IDLE.
- `core_go` to WAIT: WAIT begins the cycle after `core_go`; `core_done` may arrive at the earliest 1 cycle later.
- `core_done` → SHOW on the next edge; `last`/`best`/`sum` update on that same edge.
- Hold: SHOW and SUM_BEST each last exactly `HOLD_CYC` cycles. The counter counts 0..HOLD_CYC-1; it is 24 bits and `HOLD_CYC` must be < 2^24.
- `rst_n` assertion mid-operation forces reset values immediately, asynchronously. Deassertion is synchronized externally.

## Test plan
1. Normal session, `HOLD_CYC`=8, ROUNDS=4, results 250, 180, 300, 210:
   - `core_go` ×4, `round` 0→3, each SHOW shows `value`=result with `disp_sel`=1.
   - SUM_BEST shows 180 for 8 cycles, then SUM_AVG shows 235; `session_done`=1.
2. False start in round 1: `core_done` with `core_early`=1 →
   - `led_err`=1 and `value`=0 for 8 cycles, then `core_go` re-issued with `round`=1.
   - `sum` is unchanged.
3. Saturation: `core_ms`=12000 in one round → `last`=9999, and 9999 is added to `sum`. Live `value` in WAIT is capped at 9999.
4. Abort during WAIT coincident with `core_done`:
   - IDLE reached, `value`=0, result not accumulated.
   - Next start restarts at `round`=0 with `best`=9999.
5. Button timing and filtering:
   - `start_btn` held high for 100 cycles produces exactly one `core_go`, 3 edges after first sample.
   - Start pulses during SHOW are ignored.
   - Start in SUM_AVG begins a new session.
6. `rst_n` low in mid-SHOW: all outputs reset asynchronously within the same cycle. After release the block is in IDLE and `core_go` stays low until a start edge.
